// File: rtl/txt_pix_scan_if.sv
// Memory-side bus of txt_pix_scan: cell/glyph addresses out, cell/glyph data back.
// The memory answers each address with fixed two-clock latency and no handshake.
interface txt_pix_scan_if;
    logic [13:0]  pixCellIx;
    logic [127:0] cellData;
    logic [15:0]  fontGlyph;
    logic [63:0]  fontData;

    modport master (output pixCellIx, output fontGlyph, input cellData, input fontData);
    modport slave  (input pixCellIx, input fontGlyph, output cellData, output fontData);
endinterface

// File: rtl/txt_pix_scan.sv
// Text-mode raster scan-out: video timing, 8x8 cell addressing and glyph-to-RGB rendering.
// Optional blink support is compiled in when TXT_PIX_BLINK_EN is defined.
module txt_pix_scan #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 400,
    parameter int unsigned V_FP     = 12,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 35
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [13:0]    cellBase,
    txt_pix_scan_if.master mem,
    output logic [11:0]    pixRgb,
    output logic           pixHsync,
    output logic           pixVsync,
    output logic           pixDe,
    output logic           frameStart
);

    localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(HT);
    localparam int unsigned VW       = $clog2(VT);
    localparam int unsigned COLS     = H_ACTIVE / 8;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Sync flags are carried active-high so a cleared pipe means "no sync".
    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
    } pipe_t;

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [13:0]   rowBase_q, rowBase_d;
    logic [13:0]   frameBase_q, frameBase_d;
    logic [1:0]    live_q;
    pipe_t         p_q [4];
    pipe_t         p_new;
    logic [5:0]    fg3_q, bg3_q, fg4_q, bg4_q;
    logic          bl3_q, bl4_q;

    logic          h_wrap, v_wrap, origin, h_act, v_act;
    logic [13:0]   col;
    logic          pix_on, blank;
    logic [11:0]   pix_rgb;
    logic          unused_cell_bits;

    function automatic logic [11:0] expand(input logic [5:0] c);
        return {c[5:4], c[5:4], c[3:2], c[3:2], c[1:0], c[1:0]};
    endfunction

    always_comb begin
        h_wrap = (hcnt_q == HW'(HT - 1));
        v_wrap = (vcnt_q == VW'(VT - 1));
        origin = (hcnt_q == '0) && (vcnt_q == '0);
        h_act  = (hcnt_q < HW'(H_ACTIVE));
        v_act  = (vcnt_q < VW'(V_ACTIVE));

        hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
        end

        rowBase_d = rowBase_q;
        if (h_wrap) begin
            if (v_wrap) begin
                rowBase_d = '0;
            end else if (vcnt_q[2:0] == 3'd7) begin
                rowBase_d = rowBase_q + 14'(COLS);
            end
        end

        // At the frame origin the new base is used straight from the port.
        frameBase_d   = origin ? cellBase : frameBase_q;
        col           = h_act ? 14'(hcnt_q[HW-1:3]) : '0;
        mem.pixCellIx = frameBase_d + rowBase_q + col;

        p_new.x  = hcnt_q[2:0];
        p_new.y  = vcnt_q[2:0];
        p_new.de = h_act && v_act;
        p_new.hs = (hcnt_q >= HW'(HS_START)) && (hcnt_q < HW'(HS_END));
        p_new.vs = (vcnt_q >= VW'(VS_START)) && (vcnt_q < VW'(VS_END));
        p_new.fs = origin;

        mem.fontGlyph = live_q[1] ? mem.cellData[15:0] : '0;
    end

`ifdef TXT_PIX_BLINK_EN
    logic [5:0] frameCnt_q;

    // Counted at the timing wrap so the count equals the index of the frame on screen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frameCnt_q <= '0;
        end else if (h_wrap && v_wrap) begin
            frameCnt_q <= frameCnt_q + 6'd1;
        end
    end

    always_comb begin
        blank            = bl4_q && frameCnt_q[5];
        unused_cell_bits = ^{mem.cellData[127:32], mem.cellData[30:28]};
    end
`else
    always_comb begin
        blank            = 1'b0;
        unused_cell_bits = ^{mem.cellData[127:31], mem.cellData[30:28], bl4_q};
    end
`endif

    always_comb begin
        pix_on  = mem.fontData[~{p_q[3].y, p_q[3].x}];
        pix_rgb = expand((pix_on && !blank) ? fg4_q : bg4_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            rowBase_q   <= '0;
            frameBase_q <= '0;
            live_q      <= '0;
            p_q         <= '{default: '0};
            fg3_q       <= '0;
            bg3_q       <= '0;
            bl3_q       <= 1'b0;
            fg4_q       <= '0;
            bg4_q       <= '0;
            bl4_q       <= 1'b0;
            pixRgb      <= '0;
            pixHsync    <= 1'b1;
            pixVsync    <= 1'b1;
            pixDe       <= 1'b0;
            frameStart  <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            rowBase_q   <= rowBase_d;
            frameBase_q <= frameBase_d;
            live_q      <= {live_q[0], 1'b1};
            p_q[0]      <= p_new;
            for (int unsigned i = 1; i < 4; i++) begin
                p_q[i] <= p_q[i-1];
            end
            fg3_q       <= mem.cellData[21:16];
            bg3_q       <= mem.cellData[27:22];
            bl3_q       <= mem.cellData[31];
            fg4_q       <= fg3_q;
            bg4_q       <= bg3_q;
            bl4_q       <= bl3_q;
            pixRgb      <= p_q[3].de ? pix_rgb : '0;
            pixHsync    <= !p_q[3].hs;
            pixVsync    <= !p_q[3].vs;
            pixDe       <= p_q[3].de;
            frameStart  <= p_q[3].fs;
        end
    end

endmodule

// File: tb/tb_txt_pix_scan.sv
// Scoreboard bench for txt_pix_scan on a reduced raster (64x23 total, 6x2 cells visible).
// A behavioural memory answers the DUT; expected pixels come from an independent raster model.
module tb_txt_pix_scan;

    localparam int unsigned HA = 48, HFP = 4, HSW = 6, HBP = 6;
    localparam int unsigned VA = 16, VFP = 2, VSW = 2, VBP = 3;
    localparam int unsigned HT = HA + HFP + HSW + HBP;
    localparam int unsigned VT = VA + VFP + VSW + VBP;
    localparam int unsigned COLS  = HA / 8;
    localparam int unsigned FRAME = HT * VT;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] cellBase = '0;
    logic [11:0] pixRgb;
    logic        pixHsync, pixVsync, pixDe, frameStart;

    txt_pix_scan_if mem_if ();

    txt_pix_scan #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cellBase   (cellBase),
        .mem        (mem_if.master),
        .pixRgb     (pixRgb),
        .pixHsync   (pixHsync),
        .pixVsync   (pixVsync),
        .pixDe      (pixDe),
        .frameStart (frameStart)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cell word: {blink, 3 ignored bits, bg, fg, glyph}; cell 0 is the render test cell.
    function automatic logic [31:0] cell_of(input logic [13:0] ix);
        logic [15:0] g;
        logic [5:0]  fg;
        if (ix == 14'd0) return {1'b0, 3'b000, 6'h00, 6'h3F, 16'h0041};
        g  = 16'(ix) * 16'd37 + 16'h1234;
        fg = ix[5:0] ^ 6'h2A;
        return {ix[1], ix[4:2], fg ^ 6'h15, fg, g};
    endfunction

    function automatic logic [63:0] font_of(input logic [15:0] g);
        if (g == 16'h0041) return 64'h80C3_A55A_0F0F_F00F;
        return {g, g ^ 16'hA5C3, ~g, g * 16'd7 + 16'h0101};
    endfunction

    function automatic logic [11:0] rgb_of(input logic [5:0] c);
        return {c[5], c[4], c[5], c[4], c[3], c[2], c[3], c[2], c[1], c[0], c[1], c[0]};
    endfunction

    // Behavioural memory with two-clock latency on both ports.
    logic [127:0] cd1;
    logic [63:0]  fd1;
    logic [31:0]  cw;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cd1 <= '0; fd1 <= '0;
            mem_if.cellData <= '0;
            mem_if.fontData <= '0;
        end else begin
            cw = cell_of(mem_if.pixCellIx);
            cd1 <= {~cw, ~cw, ~cw, cw};
            fd1 <= font_of(mem_if.fontGlyph);
            mem_if.cellData <= cd1;
            mem_if.fontData <= fd1;
        end
    end

    typedef struct {
        logic [11:0] rgb;
        logic        hs, vs, de, fs;
        int          h, v;
        logic [13:0] base;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          mh = 0, mv = 0, mframe = 0;
    logic [13:0] mbase = '0;
    logic [13:0] b, ix;
    logic [31:0] c;
    logic [63:0] f;
    logic        fbit;
    logic [5:0]  colr;
    int          de_cnt = 0, cyc = 0, last_fall = 0, vs_run = 0;
    logic        have_fs = 0, hs_seen = 0, prev_hs = 1;

    function automatic exp_t reset_entry();
        exp_t r;
        r.rgb = '0; r.hs = 1'b1; r.vs = 1'b1; r.de = 1'b0; r.fs = 1'b0;
        r.h = -1; r.v = -1; r.base = '0;
        return r;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            sbq.delete();
            repeat (5) sbq.push_back(reset_entry());
            mh = 0; mv = 0; mframe = 0; mbase = '0;
            de_cnt = 0; have_fs = 0; hs_seen = 0; prev_hs = 1; vs_run = 0;
        end else begin
            b  = (mh == 0 && mv == 0) ? cellBase : mbase;
            ix = 14'(int'(b) + (mv / 8) * int'(COLS) + ((mh < int'(HA)) ? mh / 8 : 0));
            check_eq("pixCellIx", mem_if.pixCellIx, ix);
            if (mv == 8 && mh == 24 && b == 14'd0) check_eq("ix_line8_col3", mem_if.pixCellIx, 32'd9);
            if (mv == 0 && mh == 40 && b == 14'd16380) check_eq("ix_wrap", mem_if.pixCellIx, 32'd1);

            e.h = mh; e.v = mv; e.base = b;
            e.de = (mh < int'(HA)) && (mv < int'(VA));
            e.hs = !((mh >= int'(HA + HFP)) && (mh < int'(HA + HFP + HSW)));
            e.vs = !((mv >= int'(VA + VFP)) && (mv < int'(VA + VFP + VSW)));
            e.fs = (mh == 0) && (mv == 0);
            e.rgb = '0;
            if (e.de) begin
                c    = cell_of(ix);
                f    = font_of(c[15:0]);
                fbit = f[63 - 8 * (mv % 8) - (mh % 8)];
                colr = fbit ? c[21:16] : c[27:22];
`ifdef TXT_PIX_BLINK_EN
                if (c[31] && ((mframe % 64) >= 32)) colr = c[27:22];
`endif
                e.rgb = rgb_of(colr);
            end
            sbq.push_back(e);
            if (mh == 0 && mv == 0) mbase = cellBase;

            if (sbq.size() > 5) begin
                e = sbq.pop_front();
                check_eq("pixRgb", pixRgb, e.rgb);
                check_eq("pixHsync", pixHsync, e.hs);
                check_eq("pixVsync", pixVsync, e.vs);
                check_eq("pixDe", pixDe, e.de);
                check_eq("frameStart", frameStart, e.fs);
                if (e.v == 0 && e.base == 14'd0 && e.h == 0) check_eq("glyph_px00", pixRgb, 32'hFFF);
                if (e.v == 0 && e.base == 14'd0 && e.h == 1) check_eq("glyph_px10", pixRgb, 32'h000);
            end

            if (frameStart) begin
                if (have_fs) check_eq("de_per_frame", de_cnt, HA * VA);
                have_fs = 1; de_cnt = 0;
            end
            if (pixDe) de_cnt++;
            if (prev_hs && !pixHsync) begin
                if (hs_seen) check_eq("hsync_period", cyc - last_fall, HT);
                hs_seen = 1; last_fall = cyc;
            end
            prev_hs = pixHsync;
            if (!pixVsync) vs_run++;
            else if (vs_run > 0) begin
                check_eq("vsync_width", vs_run, VSW * HT);
                vs_run = 0;
            end
            cyc++;

            if (mh == int'(HT) - 1) begin
                mh = 0;
                if (mv == int'(VT) - 1) begin
                    mv = 0; mframe++;
                end else mv++;
            end else mh++;
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        run_cycles(2 * FRAME + 3 * HT + 20);

        // Asynchronous reset in the middle of a line
        #2 reset = 1'b1;
        #1;
        check_eq("rst_rgb", pixRgb, 32'h0);
        check_eq("rst_hsync", pixHsync, 32'h1);
        check_eq("rst_vsync", pixVsync, 32'h1);
        check_eq("rst_de", pixDe, 32'h0);
        check_eq("rst_fs", frameStart, 32'h0);
        check_eq("rst_cellix", mem_if.pixCellIx, cellBase);
        check_eq("rst_glyph", mem_if.fontGlyph, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        run_cycles(FRAME / 2);
        cellBase = 14'd16380;
        run_cycles(FRAME);
        cellBase = 14'd100;
        run_cycles(2 * FRAME);
`ifdef TXT_PIX_BLINK_EN
        run_cycles(34 * FRAME);
`else
        run_cycles(2 * FRAME);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/txt_pix_scan.md
# txt_pix_scan

Raster scan-out stage for the text-mode display, downstream of the text screen/font memory. It generates 640x400 video timing and walks the 80x50 grid of 8x8 character cells. Per pixel it issues the cell index and the glyph index to the memory, then turns the returned 128-bit cell and 64-bit glyph bitmap into RGB pixels with aligned sync and data-enable.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 400, visible lines (multiple of 8)
- V_FP, 12, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 35, vertical back porch

Ports:
- clock  in  1  pixel clock, rising edge
- reset  in  1  asynchronous, active-high
- cellBase  in  14  cell index of the top-left screen cell, sampled at frame start
- pixCellIx  out  14  cell index presented to screen memory
- cellData  in  128  cell contents, valid 2 clocks after pixCellIx
- fontGlyph  out  16  glyph index presented to font memory
- fontData  in  64  8x8 bitmap, valid 2 clocks after fontGlyph
- pixRgb  out  12  pixel colour {R4,G4,B4}
- pixHsync  out  1  horizontal sync, active low
- pixVsync  out  1  vertical sync, active low
- pixDe  out  1  active-video flag
- frameStart  out  1  one-clock pulse at first active pixel of a frame

## Operation
- Counters: hcnt 0..HT-1, where HT = H_ACTIVE+H_FP+H_SYNC+H_BP. vcnt 0..VT-1. vcnt increments when hcnt wraps. Active region is hcnt<H_ACTIVE && vcnt<V_ACTIVE.
- Sync: hsync is low for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC. vsync follows the same rule on vcnt.
- Cell addressing: pixCellIx = frameBase + rowBase + hcnt[..:3], computed mod 2^14.
  - rowBase is 0 at vcnt=0 and gains COLS=H_ACTIVE/8 each time vcnt[2:0] wraps 7→0. No multiplier.
  - frameBase latches cellBase when hcnt=0 and vcnt=0.
  - During horizontal blanking, pixCellIx holds frameBase+rowBase (column 0).
- Cell format: [15:0] glyph; [21:16] fg RGB222; [27:22] bg RGB222; [31] blink; [127:32] ignored.
- Stage S2 (cellData valid):
  - fontGlyph = cellData[15:0], driven combinationally.
  - fg, bg and blink are registered and carried forward 2 stages.
- Stage S4 (fontData valid): row r = y[2:0] uses bits [63-8r:56-8r]. Column x[2:0]=0 selects the MSB of that row.
- Colour: a bit value of 1 gives fg, 0 gives bg. Each 2-bit component expands as {c,c}. pixRgb is 0 whenever de is 0.
- x/y fine offsets, de, hsync, vsync and frameStart ride a 5-deep shift pipe so they stay aligned with pixRgb.

## Timing
- Latency: counter state in cycle t appears on pixRgb/pixDe/pixHsync/pixVsync in cycle t+5. All outputs are registered except pixCellIx and fontGlyph.
- One pixel per clock, no stalls. Memory latency is fixed at 2+2 clocks; there is no handshake.
- Reset (async) forces:
  - hcnt=vcnt=0, rowBase=frameBase=0, all pipe stages cleared.
  - pixRgb=0, pixHsync=1, pixVsync=1, pixDe=0, frameStart=0.
  - pixCellIx=cellBase, fontGlyph=0 (pipe contents are zero).
- After reset deasserts, the first frameStart occurs 5 clocks later.
- Reset mid-frame aborts the frame: timing restarts at (0,0), and no partial-line sync glitch is produced beyond the reset itself.
- Wrap: if cellBase+rowBase+col ≥ 16384, the index wraps to low addresses.
- Simultaneous events: when hcnt and vcnt both wrap in the same clock, rowBase resets to 0. frameBase reload takes priority over the rowBase increment.

## Configuration
- TXT_PIX_BLINK_EN defined: a 6-bit frame counter increments at each frameStart and is reset to 0. When blink=1 and frameCnt[5]=1, a pixel is drawn with bg regardless of the font bit.
- Not defined: the blink bit is ignored and there is no frame counter.

## Test plan
- Reset: assert mid-line → all outputs at reset values immediately. Release → frameStart 5 clocks later, pixDe=1 in the same cycle.
- Sync timing: count one line and one frame → HT=800, hsync low for hcnt 656..751, VT=449, vsync low for vcnt 412..413, 256000 de cycles per frame.
- Glyph render: cell 0 = {glyph 0x41, fg 0x3F, bg 0x00}, fontData row0=0x80 → pixel (0,0) pixRgb=0xFFF, pixel (1,0) pixRgb=0x000.
- Addressing: cellBase=0 → at line 8 col 3, pixCellIx=83. cellBase=16380 → col 5 of row 0 gives pixCellIx=1 (wrap).
- cellBase change mid-frame → no effect until the next frame start.
- Blink (with TXT_PIX_BLINK_EN): blink cell shows fg for frames 0-31 and bg for frames 32-63. Without the macro it shows fg in all frames.
